// File: rtl/fetch_prefetcher.sv
// Sequential instruction prefetcher feeding the instruction FIFO.
// A 2-entry skid absorbs in-flight reads; a branch redirects and flushes.
module fetch_prefetcher #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_SIZE  = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_address,
  output logic                  mem_r_en,
  output logic [ADDR_WIDTH-1:0] mem_r_adrs,
  input  logic                  mem_r_valid,
  input  logic [DATA_SIZE-1:0]  mem_r_data,
  output logic                  fifo_w_en,
  output logic [DATA_SIZE-1:0]  fifo_w_data,
  input  logic                  fifo_full,
  output logic                  fifo_flush,
  output logic [ADDR_WIDTH-1:0] fetch_pc
);

  typedef enum logic {
    FETCH,
    FLUSH
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic                    outstanding;
  logic [1:0]              skid_count;
  logic [DATA_SIZE-1:0]    skid [2];

  logic                    fetching;
  logic [2:0]              credit;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    accept;
  logic                    skid_wr;
  logic                    widx;

  assign fetching = (state == FETCH) & !branch_valid;
  assign credit   = {1'b0, skid_count} + {2'b0, outstanding};
  assign issue    = fetching & (credit < 3'd2);
  assign push     = fetching & !fifo_full
                  & ((skid_count != 2'd0) | mem_r_valid);
  assign pop      = push & (skid_count != 2'd0);
  assign accept   = fetching & mem_r_valid;

  // A response goes to the skid unless it was bypassed straight out
  assign skid_wr  = accept & !(push & (skid_count == 2'd0));
  assign widx     = ((skid_count == 2'd1) & !pop)
                  | (skid_count == 2'd2);

  assign mem_r_en    = resetn & issue;
  assign mem_r_adrs  = pc;
  assign fifo_w_en   = resetn & push;
  assign fifo_w_data = !resetn ? '0
                     : (skid_count != 2'd0) ? skid[0]
                     : mem_r_data;
  assign fifo_flush  = (state == FLUSH);
  assign fetch_pc    = pc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= FETCH;
      pc          <= '0;
      outstanding <= 1'b0;
      skid_count  <= 2'd0;
      skid[0]     <= '0;
      skid[1]     <= '0;
    end else begin
      outstanding <= issue;
      if (branch_valid) begin
        state      <= FLUSH;
        pc         <= branch_address;
        skid_count <= 2'd0;
      end else if (state == FLUSH) begin
        state <= FETCH;
      end else begin
        if (issue) pc <= pc + 1'b1;
        skid_count <= skid_count
                    + {1'b0, skid_wr}
                    - {1'b0, pop};
      end
      if (pop) skid[0] <= skid[1];
      if (skid_wr) skid[widx] <= mem_r_data;
    end
  end

  a_skid_bound: assert property (
    @(posedge clk) disable iff (!resetn)
    skid_count <= 2'd2
  );

endmodule

// File: tb/tb_fetch_prefetcher.sv
// Scoreboard bench for fetch_prefetcher: expected program-order words
// are queued by the stimulus and checked by an independent monitor.
module tb_fetch_prefetcher;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          branch_valid = 1'b0;
  logic [AW-1:0] branch_address = '0;
  logic          mem_r_en;
  logic [AW-1:0] mem_r_adrs;
  logic          mem_r_valid = 1'b0;
  logic [DW-1:0] mem_r_data = '0;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_w_data;
  logic          fifo_full = 1'b0;
  logic          fifo_flush;
  logic [AW-1:0] fetch_pc;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q [$];
  logic [AW-1:0] nxt = '0;

  // reference model state, updated once per cycle by the monitor
  logic [AW-1:0] m_pc = '0;
  int            m_inf = 0;
  logic          m_fl = 1'b0;

  fetch_prefetcher #(.ADDR_WIDTH(AW), .DATA_SIZE(DW)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .branch_valid   (branch_valid),
    .branch_address (branch_address),
    .mem_r_en       (mem_r_en),
    .mem_r_adrs     (mem_r_adrs),
    .mem_r_valid    (mem_r_valid),
    .mem_r_data     (mem_r_data),
    .fifo_w_en      (fifo_w_en),
    .fifo_w_data    (fifo_w_data),
    .fifo_full      (fifo_full),
    .fifo_flush     (fifo_flush),
    .fetch_pc       (fetch_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return 32'hA000_0000 + {21'b0, a};
  endfunction

  // one-cycle read latency memory
  always @(posedge clk) begin
    mem_r_valid <= mem_r_en;
    mem_r_data  <= memf(mem_r_adrs);
  end

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // program-order expectation: one more sequential word per live cycle
  task automatic step(input logic f, input logic b,
                      input logic [AW-1:0] a);
    @(posedge clk);
    #1;
    fifo_full      = f;
    branch_valid   = b;
    branch_address = a;
    if (b) begin
      exp_q.delete();
      nxt = a;
    end
    exp_q.push_back(memf(nxt));
    nxt = nxt + 1'b1;
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #3;
    resetn       = 1'b0;
    branch_valid = 1'b0;
    fifo_full    = 1'b0;
    exp_q.delete();
    nxt = '0;
    #1;
    chk("rst_async_r_en", {31'b0, mem_r_en}, 32'd0);
    chk("rst_async_w_en", {31'b0, fifo_w_en}, 32'd0);
    repeat (hold) @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_q.push_back(memf(nxt));
    nxt = nxt + 1'b1;
  endtask

  always @(negedge clk) begin
    logic e_iss;
    logic e_push;
    if (!resetn) begin
      chk("rst_r_en", {31'b0, mem_r_en}, 32'd0);
      chk("rst_w_en", {31'b0, fifo_w_en}, 32'd0);
      chk("rst_flush", {31'b0, fifo_flush}, 32'd0);
      chk("rst_adrs", {21'b0, mem_r_adrs}, 32'd0);
      chk("rst_pc", {21'b0, fetch_pc}, 32'd0);
      chk("rst_w_data", fifo_w_data, 32'd0);
      m_pc  = '0;
      m_inf = 0;
      m_fl  = 1'b0;
    end else begin
      e_iss  = !branch_valid && !m_fl && (m_inf < 2);
      e_push = !branch_valid && !m_fl && !fifo_full && (m_inf > 0);
      chk("flush", {31'b0, fifo_flush}, {31'b0, m_fl});
      chk("r_en", {31'b0, mem_r_en}, {31'b0, e_iss});
      chk("w_en", {31'b0, fifo_w_en}, {31'b0, e_push});
      chk("adrs", {21'b0, mem_r_adrs}, {21'b0, m_pc});
      chk("fetch_pc", {21'b0, fetch_pc}, {21'b0, m_pc});
      if (fifo_w_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w_data: push %h with empty expectation",
                   fifo_w_data);
        end else begin
          chk("w_data", fifo_w_data, exp_q.pop_front());
        end
      end
      if (branch_valid) begin
        m_pc  = branch_address;
        m_inf = 0;
      end else begin
        if (e_push) m_inf--;
        if (e_iss) begin
          m_inf++;
          m_pc = m_pc + 1'b1;
        end
      end
      m_fl = branch_valid;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_q.push_back(memf(nxt));
    nxt = nxt + 1'b1;

    repeat (8) step(1'b0, 1'b0, '0);
    repeat (6) step(1'b1, 1'b0, '0);
    checks++;
    if (m_inf != 2) begin
      errors++;
      $display("FAIL skid_hold: in flight %0d expected 2", m_inf);
    end
    for (int k = 0; k < 60 && m_pc != 11'h010; k++)
      step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 11'h100);
    repeat (10) step(1'b0, 1'b0, '0);

    step(1'b0, 1'b1, 11'h7FE);
    repeat (8) step(1'b0, 1'b0, '0);

    repeat (4) step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 11'h040);
    repeat (3) step(1'b1, 1'b0, '0);
    repeat (6) step(1'b0, 1'b0, '0);

    step(1'b0, 1'b1, 11'h200);
    step(1'b0, 1'b1, 11'h300);
    repeat (5) step(1'b0, 1'b0, '0);

    do_reset(2);
    repeat (6) step(1'b0, 1'b0, '0);

    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step($urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 4,
             AW'($urandom));
      end
    end
    step(1'b0, 1'b0, '0);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
